mmix_mem_bridge: RTL and testbench
==================================

Name: mmix_mem_bridge

Overview:
- Sits directly downstream of the CPU core's memory port.
- Converts the core's 64-bit sized requests (byte/wyde/tetra/octa, MMIX big-endian) into a 32-bit Avalon-MM style bus master with pipelined reads.
- Octa accesses become two tetra beats.
- Returns right-justified, zero-extended read data with a one-cycle done pulse; sign extension stays in the exec unit.

Parameters:
ADDR_W, 32, physical byte-address width driven on the bus (cpu_address[ADDR_W-1:0], after size alignment)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
cpu_address  input  64  virtual=physical byte address from core
cpu_datasize  input  2  0 byte, 1 wyde, 2 tetra, 3 octa
cpu_read  input  1  read request, level, held until cpu_done
cpu_write  input  1  write request, level, held until cpu_done
cpu_writedata  input  64  right-justified store data
cpu_readdata  output  64  right-justified, zero-extended load data
cpu_done  output  1  one-cycle completion pulse
av_address  output  ADDR_W  byte address, always 4-aligned
av_byteenable  output  4  bit (3-k) enables byte offset k (big-endian lanes)
av_read  output  1  bus read command
av_write  output  1  bus write command
av_writedata  output  32  byte offset k on bits [31-8k -: 8]
av_readdata  input  32  read data, same lane mapping
av_waitrequest  input  1  command stall; command held while high
av_readdatavalid  input  1  read data strobe, latency >= 1 after acceptance

Behaviour:
- Reset: state IDLE; cpu_done, av_read, av_write, av_byteenable = 0; av_address, av_writedata, cpu_readdata = 0. Reset mid-transaction aborts immediately. A readdatavalid arriving while IDLE is ignored.
- Alignment: address low bits are cleared per size (wyde bit 0, tetra bits 1:0, octa bits 2:0), per MMIX.
- Byte enables:
  - Byte: one bit, 3-a[1:0].
  - Wyde: 4'b1100 if a[1]=0, else 4'b0011.
  - Tetra/octa: 4'b1111.
- Write lanes:
  - Byte: wd[7:0] replicated 4x.
  - Wyde: wd[15:0] replicated 2x.
  - Tetra: wd[31:0].
  - Octa: beat0 wd[63:32] at aligned addr, beat1 wd[31:0] at addr+4.
- Read extraction: byte/wyde/tetra take the selected lane, zero-extended. Octa returns {beat0 data, beat1 data}.
- States: IDLE, CMD0, RESP0, CMD1, RESP1, DONE.
  - IDLE: cpu_write or cpu_read seen → latch address/size/data/direction → CMD0. Write wins if both are high.
  - CMDn: av_read/av_write asserted with stable address/enable/data. Leaves when av_waitrequest=0 at the edge:
    - write: → CMD1 if octa and n=0, else DONE.
    - read: → RESPn.
  - RESPn: commands deasserted. Leaves on av_readdatavalid: capture data; → CMD1 if octa and n=0, else DONE.
  - DONE: cpu_done=1 for exactly one cycle, cpu_readdata valid; → IDLE. The core must drop its request in the cycle after cpu_done; requests are not sampled in DONE.
- cpu_readdata holds its value from DONE until the next read's DONE. It is unchanged by writes.
- Latency, zero-wait bus, readdatavalid 1 cycle after acceptance; request seen at edge 0:
  - tetra write: av_write in cycle 1, cpu_done in cycle 2.
  - tetra read: av_read in cycle 1, data in cycle 2, cpu_done in cycle 3.
  - octa: adds 1 cycle (write) or 2 cycles (read).
- One outstanding bus transaction at any time. Bus command and data outputs are registered, not combinational from cpu_* inputs.
- Upper address bits above ADDR_W are ignored; no fault is raised.

Test Plan:
- Tetra write, addr 0x0000_1006, wd=0x11223344, waitrequest high for 2 cycles → av_address=0x1004, be=4'hF, wdata=0x11223344 held for 3 cycles; cpu_done 1 cycle after acceptance.
- Byte read, addr 0x2001, bus returns 0xAABBCCDD → be=4'b0100, cpu_readdata=0x00000000_000000BB.
- Wyde write, addr 0x3003, wd=0xBEEF → address 0x3000, be=4'b0011, wdata=0xBEEFBEEF.
- Octa read, addr 0x4005, bus returns 0x01234567 then 0x89ABCDEF with readdatavalid latency 3 → beats at 0x4000 and 0x4004; cpu_readdata=0x0123456789ABCDEF; single cpu_done.
- cpu_read and cpu_write both high, tetra at 0x5000 → av_write only, av_read never asserted.
- reset in RESP1 of an octa read, then a late readdatavalid → next cycle all outputs 0, no cpu_done, late data ignored; a following tetra read completes normally.

Source files
------------

// File: rtl/mmix_mem_bridge_if.sv
// Core-side request port and 32-bit Avalon-MM master port of the MMIX memory bridge.
// The master modport is the bridge's view; slave is the core plus memory that surround it.
interface mmix_mem_bridge_if #(
  parameter int ADDR_W = 32
);
  logic [63:0]       cpu_address;
  logic [1:0]        cpu_datasize;
  logic              cpu_read;
  logic              cpu_write;
  logic [63:0]       cpu_writedata;
  logic [63:0]       cpu_readdata;
  logic              cpu_done;

  logic [ADDR_W-1:0] av_address;
  logic [3:0]        av_byteenable;
  logic              av_read;
  logic              av_write;
  logic [31:0]       av_writedata;
  logic [31:0]       av_readdata;
  logic              av_waitrequest;
  logic              av_readdatavalid;

  modport master (
    input  cpu_address, cpu_datasize, cpu_read, cpu_write, cpu_writedata,
    output cpu_readdata, cpu_done,
    output av_address, av_byteenable, av_read, av_write, av_writedata,
    input  av_readdata, av_waitrequest, av_readdatavalid
  );

  modport slave (
    output cpu_address, cpu_datasize, cpu_read, cpu_write, cpu_writedata,
    input  cpu_readdata, cpu_done,
    input  av_address, av_byteenable, av_read, av_write, av_writedata,
    output av_readdata, av_waitrequest, av_readdatavalid
  );
endinterface

// File: rtl/mmix_mem_bridge.sv
// Converts sized big-endian MMIX core requests into 32-bit Avalon-MM beats,
// one outstanding transaction at a time; octa accesses take two tetra beats.
//
// state | meaning
// IDLE  | waiting for cpu_read/cpu_write (write wins)
// CMD0  | first beat command on the bus, held while waitrequest
// RESP0 | waiting for first beat read data
// CMD1  | second (octa) beat command at address+4
// RESP1 | waiting for second beat read data
// DONE  | cpu_done pulse, cpu_readdata valid
module mmix_mem_bridge #(
  parameter int ADDR_W = 32
) (
  input logic              clk,
  input logic              reset,
  mmix_mem_bridge_if.master bus
);

  typedef enum logic [2:0] {IDLE, CMD0, RESP0, CMD1, RESP1, DONE} state_t;

  state_t            state;
  logic              is_write;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic [31:0]       wd_lo_q;
  logic [31:0]       rd_hi_q;

  logic [ADDR_W-1:0] av_address;
  logic [3:0]        av_byteenable;
  logic              av_read;
  logic              av_write;
  logic [31:0]       av_writedata;
  logic [63:0]       cpu_readdata;
  logic              cpu_done;

  logic [ADDR_W-1:0] req_base;

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0] sz);
    logic [ADDR_W-1:0] base;
    base = a;
    case (sz)
      2'd0:    base = a;
      2'd1:    base[0] = 1'b0;
      2'd2:    base[1:0] = 2'b00;
      default: base[2:0] = 3'b000;
    endcase
    return base;
  endfunction

  function automatic logic [3:0] lane_enable(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    return 4'b1000 >> off;
      2'd1:    return off[1] ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [63:0] wd);
    case (sz)
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      2'd2:    return wd[31:0];
      default: return wd[63:32];
    endcase
  endfunction

  // Big-endian lanes: byte offset k lives in bits [31-8k -: 8].
  function automatic logic [63:0] extract(input logic [1:0] sz, input logic [1:0] off,
                                          input logic [31:0] rd);
    case (sz)
      2'd0: begin
        case (off)
          2'd0:    return {56'd0, rd[31:24]};
          2'd1:    return {56'd0, rd[23:16]};
          2'd2:    return {56'd0, rd[15:8]};
          default: return {56'd0, rd[7:0]};
        endcase
      end
      2'd1:    return {48'd0, (off[1] ? rd[15:0] : rd[31:16])};
      default: return {32'd0, rd};
    endcase
  endfunction

  assign req_base = align_addr(bus.cpu_address[ADDR_W-1:0], bus.cpu_datasize);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      is_write      <= 1'b0;
      size_q        <= 2'd0;
      off_q         <= 2'd0;
      wd_lo_q       <= '0;
      rd_hi_q       <= '0;
      av_address    <= '0;
      av_byteenable <= 4'd0;
      av_read       <= 1'b0;
      av_write      <= 1'b0;
      av_writedata  <= '0;
      cpu_readdata  <= '0;
      cpu_done      <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_write || bus.cpu_read) begin
            is_write      <= bus.cpu_write;
            size_q        <= bus.cpu_datasize;
            off_q         <= req_base[1:0];
            wd_lo_q       <= bus.cpu_writedata[31:0];
            av_address    <= {req_base[ADDR_W-1:2], 2'b00};
            av_byteenable <= lane_enable(bus.cpu_datasize, req_base[1:0]);
            av_writedata  <= lane_data(bus.cpu_datasize, bus.cpu_writedata);
            av_write      <= bus.cpu_write;
            av_read       <= ~bus.cpu_write;
            state         <= CMD0;
          end
        end
        CMD0: begin
          if (!bus.av_waitrequest) begin
            if (is_write) begin
              if (size_q == 2'd3) begin
                av_address   <= av_address + ADDR_W'(4);
                av_writedata <= wd_lo_q;
                state        <= CMD1;
              end else begin
                av_write <= 1'b0;
                cpu_done <= 1'b1;
                state    <= DONE;
              end
            end else begin
              av_read <= 1'b0;
              state   <= RESP0;
            end
          end
        end
        RESP0: begin
          if (bus.av_readdatavalid) begin
            if (size_q == 2'd3) begin
              rd_hi_q    <= bus.av_readdata;
              av_address <= av_address + ADDR_W'(4);
              av_read    <= 1'b1;
              state      <= CMD1;
            end else begin
              cpu_readdata <= extract(size_q, off_q, bus.av_readdata);
              cpu_done     <= 1'b1;
              state        <= DONE;
            end
          end
        end
        CMD1: begin
          if (!bus.av_waitrequest) begin
            if (is_write) begin
              av_write <= 1'b0;
              cpu_done <= 1'b1;
              state    <= DONE;
            end else begin
              av_read <= 1'b0;
              state   <= RESP1;
            end
          end
        end
        RESP1: begin
          if (bus.av_readdatavalid) begin
            cpu_readdata <= {rd_hi_q, bus.av_readdata};
            cpu_done     <= 1'b1;
            state        <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.av_address    = av_address;
  assign bus.av_byteenable = av_byteenable;
  assign bus.av_read       = av_read;
  assign bus.av_write      = av_write;
  assign bus.av_writedata  = av_writedata;
  assign bus.cpu_readdata  = cpu_readdata;
  assign bus.cpu_done      = cpu_done;

endmodule

// File: tb/tb_mmix_mem_bridge.sv
// Bench for mmix_mem_bridge: directed plan cases plus random sized accesses
// against a byte-array reference memory and an Avalon slave with random stalls.
module tb_mmix_mem_bridge;

  logic clk;
  logic reset;

  mmix_mem_bridge_if #(.ADDR_W(32)) bus ();

  mmix_mem_bridge #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference and bus memories ----------------
  logic [7:0] ref_mem [logic [31:0]];
  logic [7:0] bus_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] bus_byte(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] model_base(input logic [63:0] a, input logic [1:0] sz);
    int nb;
    nb = 1 << sz;
    return a[31:0] & ~(32'(nb) - 32'd1);
  endfunction

  function automatic logic [63:0] model_read(input logic [63:0] a, input logic [1:0] sz);
    logic [63:0] v;
    logic [31:0] b;
    v = 64'd0;
    b = model_base(a, sz);
    for (int i = 0; i < (1 << sz); i++) v = (v << 8) | 64'(ref_byte(b + 32'(i)));
    return v;
  endfunction

  task automatic model_write(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
    int n;
    logic [31:0] b;
    n = 1 << sz;
    b = model_base(a, sz);
    for (int i = 0; i < n; i++) ref_mem[b + 32'(i)] = wd[8*(n-1-i) +: 8];
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      ref_mem[a + 32'(k)] = w[8*(3-k) +: 8];
      bus_mem[a + 32'(k)] = w[8*(3-k) +: 8];
    end
  endtask

  // ---------------- Avalon slave ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          hold;
    bit          stable;
  } beat_t;

  beat_t       beat_q[$];
  bit          saw_read;
  int          cfg_wait;
  int          cfg_lat;
  int          wait_left;
  int          hold;
  bit          stable;
  logic [31:0] first_addr, first_wd;
  logic [3:0]  first_be;
  bit          rd_pending;
  int          rd_cnt;
  logic [31:0] rd_data;

  initial begin
    saw_read = 0; cfg_wait = 0; cfg_lat = 1; wait_left = 0; hold = 0; stable = 1;
    rd_pending = 0; rd_cnt = 0; rd_data = '0;
    first_addr = '0; first_wd = '0; first_be = '0;
    bus.av_waitrequest   = 1'b0;
    bus.av_readdatavalid = 1'b0;
    bus.av_readdata      = '0;
  end

  always @(negedge clk) begin
    bus.av_readdatavalid = 1'b0;
    bus.av_readdata      = $urandom;
    if (rd_pending) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        bus.av_readdatavalid = 1'b1;
        bus.av_readdata      = rd_data;
        rd_pending           = 0;
      end
    end
    if (bus.av_read) saw_read = 1;
    if (bus.av_read || bus.av_write) begin
      if (hold == 0) begin
        first_addr = bus.av_address; first_be = bus.av_byteenable; first_wd = bus.av_writedata;
        stable = 1;
      end else if (bus.av_address !== first_addr || bus.av_byteenable !== first_be ||
                   (bus.av_write && bus.av_writedata !== first_wd)) begin
        stable = 0;
      end
      hold++;
      if (wait_left > 0) begin
        bus.av_waitrequest = 1'b1;
        wait_left--;
      end else begin
        bus.av_waitrequest = 1'b0;
        beat_q.push_back('{bus.av_write, bus.av_address, bus.av_byteenable,
                           bus.av_writedata, hold, stable});
        if (bus.av_write) begin
          for (int k = 0; k < 4; k++)
            if (bus.av_byteenable[3-k]) bus_mem[bus.av_address + 32'(k)] = bus.av_writedata[8*(3-k) +: 8];
        end else begin
          for (int k = 0; k < 4; k++) rd_data[8*(3-k) +: 8] = bus_byte(bus.av_address + 32'(k));
          rd_cnt     = (cfg_lat > 0) ? cfg_lat : int'($urandom_range(1, 3));
          rd_pending = 1;
        end
        hold      = 0;
        wait_left = (cfg_wait >= 0) ? cfg_wait : int'($urandom_range(0, 2));
      end
    end else begin
      bus.av_waitrequest = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- core-side driver ----------------
  task automatic do_op(input logic wr, input logic rd, input logic [1:0] sz,
                       input logic [63:0] a, input logic [63:0] wd,
                       output logic [63:0] rdata, output int lat);
    int cyc;
    bit seen;
    beat_q.delete();
    saw_read          = 0;
    bus.cpu_address   = a;
    bus.cpu_datasize  = sz;
    bus.cpu_writedata = wd;
    bus.cpu_write     = wr;
    bus.cpu_read      = rd;
    cyc  = 0;
    seen = 0;
    rdata = '0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.cpu_done) begin
        seen  = 1;
        rdata = bus.cpu_readdata;
      end
    end
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    check_val("done_seen", 64'(seen), 64'd1);
    lat = cyc;
    @(negedge clk);
    check_val("done_one_cycle", 64'(bus.cpu_done), 64'd0);
  endtask

  logic [63:0] rdata, last_rd, exp;
  int          lat;

  initial begin
    bus.cpu_address = '0; bus.cpu_datasize = '0; bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0; bus.cpu_writedata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_done",  64'(bus.cpu_done), 64'd0);
    check_val("rst_read",  64'(bus.av_read), 64'd0);
    check_val("rst_write", 64'(bus.av_write), 64'd0);
    check_val("rst_be",    64'(bus.av_byteenable), 64'd0);
    check_val("rst_addr",  64'(bus.av_address), 64'd0);
    check_val("rst_wdata", 64'(bus.av_writedata), 64'd0);
    check_val("rst_rdata", bus.cpu_readdata, 64'd0);
    reset = 1'b0;
    last_rd = '0;

    // Tetra write with two stall cycles.
    cfg_wait = 2; wait_left = 2; cfg_lat = 1;
    do_op(1, 0, 2'd2, 64'h1006, 64'h11223344, rdata, lat);
    model_write(64'h1006, 2'd2, 64'h11223344);
    check_val("tw_beats", 64'(beat_q.size()), 64'd1);
    if (beat_q.size() == 1) begin
      check_val("tw_addr",   64'(beat_q[0].addr), 64'h1004);
      check_val("tw_be",     64'(beat_q[0].be), 64'hF);
      check_val("tw_wd",     64'(beat_q[0].wd), 64'h11223344);
      check_val("tw_hold",   64'(beat_q[0].hold), 64'd3);
      check_val("tw_stable", 64'(beat_q[0].stable), 64'd1);
    end
    check_val("tw_lat", 64'(lat), 64'd4);

    // Byte read from a preloaded word.
    cfg_wait = 0; wait_left = 0; cfg_lat = 1;
    preload(32'h2000, 32'hAABBCCDD);
    do_op(0, 1, 2'd0, 64'h2001, 64'h0, rdata, lat);
    check_val("br_be",    64'(beat_q.size() > 0 ? beat_q[0].be : 4'hx), 64'h4);
    check_val("br_rdata", rdata, 64'hBB);
    check_val("br_lat",   64'(lat), 64'd3);
    last_rd = 64'hBB;

    // Wyde write to the upper-half address; read data must stay put.
    do_op(1, 0, 2'd1, 64'h3003, 64'hBEEF, rdata, lat);
    model_write(64'h3003, 2'd1, 64'hBEEF);
    check_val("ww_addr",  64'(beat_q.size() > 0 ? beat_q[0].addr : 32'hx), 64'h3000);
    check_val("ww_be",    64'(beat_q.size() > 0 ? beat_q[0].be : 4'hx), 64'h3);
    check_val("ww_wd",    64'(beat_q.size() > 0 ? beat_q[0].wd : 32'hx), 64'hBEEFBEEF);
    check_val("ww_lat",   64'(lat), 64'd2);
    check_val("ww_rdhold", bus.cpu_readdata, last_rd);

    // Octa read with readdatavalid latency 3.
    cfg_lat = 3;
    preload(32'h4000, 32'h01234567);
    preload(32'h4004, 32'h89ABCDEF);
    do_op(0, 1, 2'd3, 64'h4005, 64'h0, rdata, lat);
    check_val("or_beats", 64'(beat_q.size()), 64'd2);
    if (beat_q.size() == 2) begin
      check_val("or_addr0", 64'(beat_q[0].addr), 64'h4000);
      check_val("or_addr1", 64'(beat_q[1].addr), 64'h4004);
    end
    check_val("or_rdata", rdata, 64'h0123456789ABCDEF);
    last_rd = rdata;

    // Zero-wait latencies for octa write and octa read.
    cfg_lat = 1;
    do_op(1, 0, 2'd3, 64'h4800, 64'hCAFEF00D_12345678, rdata, lat);
    model_write(64'h4800, 2'd3, 64'hCAFEF00D_12345678);
    check_val("ow_lat", 64'(lat), 64'd3);
    do_op(0, 1, 2'd3, 64'h4800, 64'h0, rdata, lat);
    check_val("or2_lat",   64'(lat), 64'd5);
    check_val("or2_rdata", rdata, 64'hCAFEF00D_12345678);
    last_rd = rdata;

    // Read and write both requested: write wins.
    do_op(1, 1, 2'd2, 64'h5000, 64'h0BADBEEF, rdata, lat);
    model_write(64'h5000, 2'd2, 64'h0BADBEEF);
    check_val("both_noread", 64'(saw_read), 64'd0);
    check_val("both_write",  64'(beat_q.size() > 0 ? beat_q[0].wr : 1'bx), 64'd1);

    // Reset while waiting for the second octa beat, then late data.
    begin
      int  cyc;
      bit  any_done;
      cfg_lat = 4;
      beat_q.delete();
      bus.cpu_address = 64'h6000; bus.cpu_datasize = 2'd3;
      bus.cpu_write = 1'b0; bus.cpu_read = 1'b1;
      cyc = 0;
      while (beat_q.size() < 2 && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      check_val("rr_reach", 64'(beat_q.size()), 64'd2);
      @(negedge clk);
      reset = 1'b1;
      bus.cpu_read = 1'b0;
      @(negedge clk);
      check_val("rr_read",  64'(bus.av_read), 64'd0);
      check_val("rr_done",  64'(bus.cpu_done), 64'd0);
      check_val("rr_addr",  64'(bus.av_address), 64'd0);
      check_val("rr_be",    64'(bus.av_byteenable), 64'd0);
      check_val("rr_rdata", bus.cpu_readdata, 64'd0);
      reset = 1'b0;
      any_done = 0;
      repeat (8) begin
        @(negedge clk);
        if (bus.cpu_done || bus.av_read || bus.av_write) any_done = 1;
      end
      check_val("rr_late_ignored", 64'(any_done), 64'd0);
      check_val("rr_rdata_after", bus.cpu_readdata, 64'd0);
      cfg_lat = 1;
      do_op(0, 1, 2'd2, 64'h6000, 64'h0, rdata, lat);
      check_val("rr_next_rdata", rdata, model_read(64'h6000, 2'd2));
      check_val("rr_next_lat",   64'(lat), 64'd3);
      last_rd = rdata;
    end

    // Random sized accesses with random stalls and read latency.
    cfg_wait = -1; cfg_lat = 0;
    for (int i = 0; i < 300; i++) begin
      logic        wr;
      logic [1:0]  sz;
      logic [63:0] a, wd;
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = {$urandom, 32'h0000_8000 + 32'($urandom_range(0, 63))};
      wd = {$urandom, $urandom};
      do_op(wr, ~wr, sz, a, wd, rdata, lat);
      check_val("rnd_beats", 64'(beat_q.size()), (sz == 2'd3) ? 64'd2 : 64'd1);
      if (beat_q.size() > 0)
        check_val("rnd_addr", 64'(beat_q[0].addr), 64'(model_base(a, sz) & 32'hFFFF_FFFC));
      if (wr) begin
        model_write(a, sz, wd);
        check_val("rnd_rdhold", bus.cpu_readdata, last_rd);
      end else begin
        exp = model_read(a, sz);
        check_val("rnd_rdata", rdata, exp);
        last_rd = exp;
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
